shake128_squeeze: RTL and testbench

//  Squeeze-side reader for the SHAKE128 sponge. Captures the 1344-bit rate portion (lanes 0..20) of the

---
 rtl/shake128_squeeze.sv | 124 ++++++++++++
 tb/tb_shake128_squeeze.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake128_squeeze.sv
// SHAKE128 squeeze reader: streams the 21 rate lanes of each permuted Keccak state as 64-bit words
// and requests more permutations on demand. Define SHAKE_SQZ_PERM_CNT_EN to add the perm_count port.
module shake128_squeeze #(
  parameter int RATE_LANES = 21,
  parameter int LANE_W     = 64,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    req_words,
  input  logic [25*LANE_W-1:0] state_in,
  input  logic                perm_done,
  output logic                perm_start,
  output logic [LANE_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                busy,
  output logic                done
`ifdef SHAKE_SQZ_PERM_CNT_EN
  ,
  output logic [15:0]         perm_count
`endif
);

  localparam int IDX_W = $clog2(RATE_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  // The rate capture happens on the edge that leaves IDLE/WAIT_PERM, so loading costs no extra cycle.
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_PERM, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   remaining;
  logic [LANE_W-1:0]  lane_buf [RATE_LANES];

  logic last_hs;
  logic perm_req;
  logic unused_capacity;

  assign last_hs  = (state == STREAM) && dout_ready && (remaining == CNT_W'(1));
  assign perm_req = (state == STREAM) && dout_ready && (remaining != CNT_W'(1)) && (idx == LAST_IDX);

  // Capacity lanes 21..24 are never squeezed.
  assign unused_capacity = ^state_in[25*LANE_W-1:RATE_LANES*LANE_W];

  // The buffer shifts toward lane 0 on each handshake, so dout is a plain register.
  assign dout      = lane_buf[0];
  assign dout_last = dout_valid && (remaining == CNT_W'(1));
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      remaining  <= '0;
      dout_valid <= 1'b0;
      perm_start <= 1'b0;
      done       <= 1'b0;
      // NOTE: the lane buffer is reset too, so dout reads zero out of reset rather than stale key stream.
      for (int i = 0; i < RATE_LANES; i++) lane_buf[i] <= '0;
    end else begin
      perm_start <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (req_words == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              for (int i = 0; i < RATE_LANES; i++) lane_buf[i] <= state_in[i*LANE_W +: LANE_W];
              remaining  <= req_words;
              idx        <= '0;
              dout_valid <= 1'b1;
              state      <= STREAM;
            end
          end
        end
        STREAM: begin
          if (dout_ready) begin
            for (int i = 0; i < RATE_LANES - 1; i++) lane_buf[i] <= lane_buf[i+1];
            idx       <= idx + 1'b1;
            remaining <= remaining - 1'b1;
            if (last_hs) begin
              dout_valid <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else if (perm_req) begin
              dout_valid <= 1'b0;
              perm_start <= 1'b1;
              state      <= WAIT_PERM;
            end
          end
        end
        WAIT_PERM: begin
          if (perm_done) begin
            for (int i = 0; i < RATE_LANES; i++) lane_buf[i] <= state_in[i*LANE_W +: LANE_W];
            idx        <= '0;
            dout_valid <= 1'b1;
            state      <= STREAM;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHAKE_SQZ_PERM_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perm_count <= '0;
    end else if (state == IDLE && start) begin
      perm_count <= '0;
    end else if (perm_req && perm_count != 16'hFFFF) begin
      perm_count <= perm_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shake128_squeeze.sv
// Self-checking bench for shake128_squeeze: a queue-based model of the squeezed word stream is
// compared against the DUT every cycle, with directed scenarios and randomized requests.
module tb_shake128_squeeze;
  localparam int RL = 21;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          perm_done = 1'b0;
  logic          dout_ready = 1'b0;
  logic [15:0]   req_words = '0;
  logic [1599:0] state_in = '0;
  logic          perm_start, dout_valid, dout_last, busy, done;
  logic [63:0]   dout;
`ifdef SHAKE_SQZ_PERM_CNT_EN
  logic [15:0]   perm_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: words still owed by the DUT, plus timing expectations.
  logic [63:0] exp_q[$];
  logic [63:0] log_q[$];
  int to_queue = 0;
  int done_in  = 0;
  int popped   = 0;
  int done_cnt = 0;
  int perm_cnt = 0;
  bit perm_in = 0, start_block = 0, perm_block = 0;

  shake128_squeeze dut (
    .clk(clk), .rst(rst), .start(start), .req_words(req_words), .state_in(state_in),
    .perm_done(perm_done), .perm_start(perm_start), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
`ifdef SHAKE_SQZ_PERM_CNT_EN
    , .perm_count(perm_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1599:0] lane_state(input int base);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = 64'(base + i);
    return s;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s;
    for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom();
    return s;
  endfunction

  task automatic model_fill(input logic [1599:0] st);
    int n;
    n = (to_queue < RL) ? to_queue : RL;
    for (int i = 0; i < n; i++) exp_q.push_back(st[i*64 +: 64]);
    to_queue -= n;
  endtask

  task automatic model_reset();
    exp_q.delete();
    log_q.delete();
    to_queue = 0; done_in = 0; perm_in = 0; start_block = 0; perm_block = 0;
  endtask

  // Compare process: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin : compare
    bit ev, ed, eb, ep;
    ev = (exp_q.size() != 0) && !start_block && !perm_block;
    ed = (done_in == 1);
    if (done_in > 0) done_in--;
    ep = perm_in;
    perm_in = 0;
    eb = ed || (((exp_q.size() != 0) || (to_queue != 0)) && !start_block);
    start_block = 0;
    perm_block  = 0;
    check("dout_valid", dout_valid, ev);
    check("done", done, ed);
    check("perm_start", perm_start, ep);
    check("busy", busy, eb);
    if (done) done_cnt++;
    if (perm_start) perm_cnt++;
    if (ev && dout_valid) begin
      check("dout", dout, exp_q[0]);
      check("dout_last", dout_last, (exp_q.size() == 1) && (to_queue == 0));
      if (dout_ready) begin
        log_q.push_back(dout);
        void'(exp_q.pop_front());
        popped++;
        if (exp_q.size() == 0) begin
          if (to_queue == 0) done_in = 1;
          else perm_in = 1;
        end
      end
    end
  end

  task automatic do_start(input logic [1599:0] st, input int n);
    @(posedge clk); #1;
    log_q.delete();
    state_in  = st;
    req_words = 16'(n);
    start     = 1'b1;
    to_queue  = n;
    if (n == 0) done_in = 2;
    else begin
      start_block = 1;
      model_fill(st);
    end
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random. perm_base < 0 gives random refills.
  task automatic run(input int mode, input bit stray, input int perm_base,
                     input int stop_words, input int budget);
    int base_done, base_pop, wait_c, cyc;
    bit finished;
    logic [1599:0] st;
    base_done = done_cnt; base_pop = popped; wait_c = -1; cyc = 0; finished = 0;
    while (!finished) begin
      @(posedge clk); #1;
      start = 1'b0;
      perm_done = 1'b0;
      if (done_cnt > base_done || (stop_words >= 0 && popped - base_pop >= stop_words)) begin
        finished = 1;
      end else if (cyc >= budget) begin
        n_checks++;
        $display("FAIL timeout: no completion after %0d cycles, expected done pulse", cyc);
        finished = 1;
      end else begin
        cyc++;
        case (mode)
          0:       dout_ready = 1'b1;
          1:       dout_ready = (cyc % 3 == 1);
          default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        if (perm_start) wait_c = $urandom_range(0, 3);
        if (wait_c == 0) begin
          st = (perm_base < 0) ? rand_state() : lane_state(perm_base);
          state_in   = st;
          perm_done  = 1'b1;
          perm_block = 1;
          model_fill(st);
          wait_c = -1;
        end else if (wait_c > 0) begin
          wait_c--;
        end else if (stray && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            start = 1'b1;
            req_words = 16'($urandom());
          end else begin
            perm_done = 1'b1;
          end
        end
      end
    end
  endtask

  initial begin
    int d0, p0, n;

    @(posedge clk); #1;
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_perm_start", perm_start, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dout", dout, 64'd0);
    @(posedge clk); #3 rst = 1'b0;

    // Three words from one block, ready held high.
    d0 = done_cnt; p0 = perm_cnt;
    do_start(lane_state(0), 3);
    run(0, 0, 0, -1, 100);
    check("t1_count", log_q.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_word", log_q[i], 64'(i));
    check("t1_done_pulses", done_cnt - d0, 1);

    // Crossing one permutation: 21 words, then lane 0 of the refill.
    repeat (2) @(posedge clk);
    d0 = done_cnt; p0 = perm_cnt;
    do_start(lane_state(0), 22);
    run(0, 0, 100, -1, 200);
    check("t2_count", log_q.size(), 22);
    check("t2_word20", log_q[20], 64'd20);
    check("t2_word21", log_q[21], 64'd100);
    check("t2_perms", perm_cnt - p0, 1);
    check("t2_done_pulses", done_cnt - d0, 1);
`ifdef SHAKE_SQZ_PERM_CNT_EN
    check("t2_perm_count", perm_count, 16'd1);
`endif

    // Back-pressure pattern.
    repeat (2) @(posedge clk);
    do_start(lane_state(0), 4);
    run(1, 0, 0, -1, 100);
    check("t3_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_word", log_q[i], 64'(i));

    // Zero-length request.
    repeat (2) @(posedge clk);
    d0 = done_cnt; p0 = perm_cnt;
    do_start(lane_state(0), 0);
    run(0, 0, 0, -1, 20);
    check("t4_count", log_q.size(), 0);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_perms", perm_cnt - p0, 0);

    // Reset in the middle of a ten-word request.
    repeat (2) @(posedge clk);
    do_start(lane_state(0), 10);
    run(0, 0, 0, 5, 100);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_dout_valid", dout_valid, 1'b0);
    check("mid_rst_perm_start", perm_start, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dout_last", dout_last, 1'b0);
    check("mid_rst_dout", dout, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    do_start(lane_state(500), 2);
    run(0, 0, 0, -1, 100);
    check("t5_count", log_q.size(), 2);
    check("t5_word0", log_q[0], 64'd500);
    check("t5_word1", log_q[1], 64'd501);

    // Stray start and perm_done pulses during streaming.
    repeat (2) @(posedge clk);
    p0 = perm_cnt;
    do_start(lane_state(0), 5);
    run(2, 1, 0, -1, 200);
    check("t6_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) check("t6_word", log_q[i], 64'(i));
    check("t6_perms", perm_cnt - p0, 0);

    // Exact block boundaries.
    repeat (2) @(posedge clk);
    p0 = perm_cnt;
    do_start(rand_state(), 21);
    run(2, 0, -1, -1, 500);
    check("b21_count", log_q.size(), 21);
    check("b21_perms", perm_cnt - p0, 0);
    repeat (2) @(posedge clk);
    p0 = perm_cnt;
    do_start(rand_state(), 42);
    run(2, 0, -1, -1, 1000);
    check("b42_count", log_q.size(), 42);
    check("b42_perms", perm_cnt - p0, 1);

    // Randomized requests.
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      n = $urandom_range(1, 70);
      p0 = perm_cnt;
      do_start(rand_state(), n);
      run(2, k[0], -1, -1, 2000);
      check("rnd_count", log_q.size(), 64'(n));
      check("rnd_perms", perm_cnt - p0, 64'((n - 1) / RL));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
